// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester-side and FIFO-side signals of the write arbiter
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          fifo_full;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [IW-1:0]                 grant_id;
  logic                          busy;
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr, fifo_wr_data, grant_id, busy
  );
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr, fifo_wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter merging NUM_REQ writers into one shared FIFO
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input logic               clk,
  input logic               reset,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_LEN) + 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t        state_q;
  logic [IW-1:0] grant_q, last_q, win_d, cand;
  logic [BW-1:0] beat_q;
  logic          busy, gvalid, xfer, last_beat;
  // scan farthest-first so the requester nearest after last_q is assigned last and wins
  always_comb begin
    win_d = last_q;
    cand  = last_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (bus.req_valid[cand]) win_d = cand;
    end
  end
  assign busy             = state_q == GRANT;
  assign gvalid           = bus.req_valid[grant_q];
  assign xfer             = busy & gvalid & ~bus.fifo_full;
  assign last_beat        = beat_q == BW'(BURST_LEN - 1);
  assign bus.busy         = busy;
  assign bus.grant_id     = grant_q;
  assign bus.fifo_wr      = xfer;
  assign bus.fifo_wr_data = bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign bus.req_ready    = (busy && !bus.fifo_full) ? NUM_REQ'(1) << grant_q : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else if (state_q == IDLE) begin
      if (|bus.req_valid) begin
        state_q <= GRANT;
        grant_q <= win_d;
        beat_q  <= '0;
      end
    end else if (!gvalid || (xfer && last_beat)) begin
      state_q <= IDLE;
      last_q  <= grant_q;
    end else if (xfer) begin
      beat_q <= beat_q + BW'(1);
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter: DATA_WIDTH, default 8, bit width of one data word.
REQ-003 Parameter: BURST_LEN, default 4, maximum beats per grant (1..16).
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 Port: req_valid  input  NUM_REQ  bit i = requester i has a word to write.
REQ-007 Port: req_data  input  NUM_REQ*DATA_WIDTH  requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port: req_ready  output  NUM_REQ  bit i = word from requester i accepted this cycle if req_valid[i].
REQ-009 Port: fifo_full  input  1  shared FIFO cannot accept a write this cycle.
REQ-010 Port: fifo_wr  output  1  write strobe to shared FIFO.
REQ-011 Port: fifo_wr_data  output  DATA_WIDTH  word written to shared FIFO.
REQ-012 Port: grant_id  output  clog2(NUM_REQ)  index of current/last granted requester.
REQ-013 Port: busy  output  1  high while in GRANT state.

Function
REQ-014 FSM SHALL have two states: IDLE, GRANT.
REQ-015 IDLE: if any req_valid bit set, SHALL select winner round-robin, searching upward from (last_grant+1) mod NUM_REQ, register grant_id, clear beat_cnt, enter GRANT next edge.
REQ-016 IDLE with no req_valid SHALL remain IDLE; grant_id holds.
REQ-017 Arbitration latency SHALL be exactly one cycle: first transfer possible in first GRANT cycle.
REQ-018 In GRANT, req_ready[grant_id] SHALL equal ~fifo_full; all other req_ready bits SHALL be 0; all req_ready bits 0 in IDLE.
REQ-019 fifo_wr SHALL equal busy & req_valid[grant_id] & ~fifo_full (combinational); fifo_wr SHALL never be high while fifo_full is high.
REQ-020 fifo_wr_data SHALL equal req_data slice of grant_id (combinational, valid whenever fifo_wr=1).
REQ-021 Transfer = fifo_wr high at clock edge; each transfer SHALL increment beat_cnt by 1 (width clog2(BURST_LEN)+1, no wrap).
REQ-022 fifo_full high in GRANT SHALL stall: beat_cnt holds, grant holds, no timeout.
REQ-023 GRANT SHALL release (return to IDLE, last_grant <= grant_id) when a transfer occurs with beat_cnt == BURST_LEN-1, or when req_valid[grant_id] is 0 in a GRANT cycle.
REQ-024 Release SHALL cost one IDLE bubble cycle before the next grant; max throughput = BURST_LEN words per BURST_LEN+1 cycles.
REQ-025 Requester i dropping req_valid while not granted SHALL have no effect on state.
REQ-026 Simultaneous fifo_full deassert and burst-final beat: transfer occurs, release occurs same edge.
REQ-027 Starvation bound: any requester holding req_valid SHALL be granted within NUM_REQ-1 intervening grants.

Reset
REQ-028 reset low SHALL immediately (without clock) force state IDLE, beat_cnt 0, grant_id 0, last_grant NUM_REQ-1 (so requester 0 wins first).
REQ-029 During and after reset, until first GRANT: fifo_wr 0, req_ready all 0, busy 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst; no partial state survives; words already written are not retracted.
REQ-031 Reset deassertion SHALL be consumed synchronously; first arbitration at first rising edge with reset high.

Verification
REQ-032 Single requester: NUM_REQ=4, BURST_LEN=4, req_valid=0001 continuously, fifo_full=0, data 0x10,0x11,... -> writes 0x10-0x13, bubble, 0x14-0x17; busy pattern 0,1,1,1,1,0,1,...
REQ-033 Round-robin: req_valid=1111 held -> grant_id sequence 0,1,2,3,0 with 4 beats each, one IDLE cycle between grants.
REQ-034 Backpressure: requester 2 granted, fifo_full=1 for 3 cycles after beat 1 -> fifo_wr=0, req_ready=0 for those 3 cycles, beats 2-4 resume, exactly 4 words total, no duplication or loss.
REQ-035 Early release: requester 1 granted, req_valid[1] drops after 2 beats -> release, next grant to requester 2 if valid, last_grant=1.
REQ-036 Async reset mid-burst: reset low between clock edges during beat 3 -> busy, fifo_wr, req_ready drop to 0 before next edge; after release req_valid=1111 -> grant_id=0 first.
REQ-037 Scoreboard on all random runs: FIFO-side word order equals per-requester order; fifo_wr never high with fifo_full high.
